signmag_divider: RTL

Sequential sign-magnitude divider for the ALU datapath. It is the inverse of the ALU's sign-magnitude multiply unit and uses the same operand format: bit 7 is the sign and bits [6:0] are the magnitude. The divider is a restoring shift-subtract design that resolves one quotient bit per clock and reports completion with a one-cycle DONE pulse. The ALU controller owns the START/BUSY/DONE handshake.

---
 rtl/signmag_divider.sv | 128 ++++++++++++
 1 files changed

// File: rtl/signmag_divider.sv
// rtl/signmag_divider.sv - sequential restoring sign-magnitude divider, one quotient bit per clock
module signmag_divider (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] DATA1,
    input  logic [7:0] DATA2,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] QUOTIENT,
    output logic [7:0] REMAINDER,
    output logic       DIV_ZERO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [6:0] dvd;
    logic [6:0] dvs;
    logic [6:0] q;
    logic [7:0] r;
    logic [2:0] cnt;
    logic       s1;
    logic       s2;
    logic       zero;

    logic [7:0] r_shift;
    logic [7:0] r_next;
    logic       q_bit;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = (DATA2[6:0] == 7'd0) ? S_FIN : S_DIV;
                end
            end
            S_DIV: begin
                if (cnt == 3'd6) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state == S_DIV) || (state == S_FIN);
    end

    // Dividend bits are consumed MSB first by shifting dvd left each step.
    always_comb begin
        r_shift = (r << 1) | {7'd0, dvd[6]};
        q_bit   = (r_shift >= {1'b0, dvs});
        r_next  = q_bit ? (r_shift - {1'b0, dvs}) : r_shift;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            dvd       <= 7'd0;
            dvs       <= 7'd0;
            q         <= 7'd0;
            r         <= 8'd0;
            cnt       <= 3'd0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            zero      <= 1'b0;
            DONE      <= 1'b0;
            QUOTIENT  <= 8'h00;
            REMAINDER <= 8'h00;
            DIV_ZERO  <= 1'b0;
        end else begin
            DONE <= (state == S_FIN);
            case (state)
                S_IDLE: begin
                    if (START) begin
                        dvd  <= DATA1[6:0];
                        dvs  <= DATA2[6:0];
                        // A -0 dividend carries no sign, so results never inherit it.
                        s1   <= DATA1[7] & (|DATA1[6:0]);
                        s2   <= DATA2[7];
                        r    <= 8'd0;
                        q    <= 7'd0;
                        cnt  <= 3'd0;
                        zero <= (DATA2[6:0] == 7'd0);
                    end
                end
                S_DIV: begin
                    r   <= r_next;
                    q   <= {q[5:0], q_bit};
                    dvd <= {dvd[5:0], 1'b0};
                    cnt <= cnt + 3'd1;
                end
                S_FIN: begin
                    if (zero) begin
                        QUOTIENT  <= {s1 ^ s2, 7'h7F};
                        REMAINDER <= {s1, dvd};
                        DIV_ZERO  <= 1'b1;
                    end else begin
                        QUOTIENT  <= {(s1 ^ s2) & (|q), q};
                        REMAINDER <= {s1 & (|r[6:0]), r[6:0]};
                        DIV_ZERO  <= 1'b0;
                    end
                end
                default: begin
                    cnt <= 3'd0;
                end
            endcase
        end
    end

endmodule
